// File: rtl/ibuf_feed_pkg.sv
// Shared constants, FSM encoding and mask-bit selection for the input-buffer feeder.
package ibuf_feed_pkg;

   localparam int AW      = 8;
   localparam int DW      = 16;
   localparam int SEL_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // Mask words are packed first-word-at-MSB; a short final group is packed down against bit 0.
   function automatic logic [3:0] mask_bit_sel(input logic [AW-1:0] idx, input logic [AW-1:0] run);
      logic [AW-1:0] remain;
      remain = run - {idx[AW-1:4], 4'b0000};
      if (remain >= AW'(16)) return 4'd15 - idx[3:0];
      return remain[3:0] - 4'd1 - idx[3:0];
   endfunction

endpackage

// File: rtl/ibuf_feed_if.sv
// Bus-write and array-stream signals of the input-buffer feeder.
interface ibuf_feed_if;
   import ibuf_feed_pkg::*;

   logic [SEL_BIT:0] ibus_wadr;
   logic [DW-1:0]    ibus_wdata;
   logic             ibus_wen;
   logic [AW-1:0]    run_cntr;
   logic             start;
   logic             s_rdy;
   logic             i_running;
   logic             finish;
   logic             sw;
   logic [DW-1:0]    s_in;
   logic             s_mask;

   modport master (
      output ibus_wadr, ibus_wdata, ibus_wen, run_cntr, start, s_rdy,
      input  i_running, finish, sw, s_in, s_mask
   );

   modport slave (
      input  ibus_wadr, ibus_wdata, ibus_wen, run_cntr, start, s_rdy,
      output i_running, finish, sw, s_in, s_mask
   );

endinterface

// File: rtl/ibuf_skid.sv
// Two-entry skid FIFO; the head entry registers drive the stream outputs directly.
module ibuf_skid import ibuf_feed_pkg::*; #(
   parameter int W = DW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_rdy,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic         tail_valid;
   logic [W-1:0] tail_data;
   logic         pop;

   assign pop = out_valid & out_rdy;
   assign occ = {1'b0, out_valid} + {1'b0, tail_valid};

   // The producer never pushes into a full FIFO, so push-without-pop with both entries busy cannot occur.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         tail_valid <= 1'b0;
         tail_data  <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         tail_valid <= 1'b0;
      end else begin
         case ({in_valid, pop})
            2'b01: begin
               out_valid  <= tail_valid;
               if (tail_valid) out_data <= tail_data;
               tail_valid <= 1'b0;
            end
            2'b10: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
               end else begin
                  tail_valid <= 1'b1;
                  tail_data  <= in_data;
               end
            end
            2'b11: begin
               if (tail_valid) begin
                  out_data  <= tail_data;
                  tail_data <= in_data;
               end else begin
                  out_data  <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sbuf_1r1w.sv
// Simple one-read one-write RAM with a registered read port that holds between reads.
module sbuf_1r1w #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // NOTE: the storage array is deliberately not reset, so contents survive rst_n and map onto RAM macros.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // NOTE: clocked state always uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ibuf_feed.sv
// Streams run_cntr operand words plus unpacked mask bits from the bus-loaded RAMs into the array.
module ibuf_feed import ibuf_feed_pkg::*; (
   input logic       clk,
   input logic       rst_n,
   ibuf_feed_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] run_q, issued_q, accepted_q, fl_idx_q;
   logic          fl_q;
   logic [DW-1:0] data_rdata, mask_rdata;
   logic [DW:0]   skid_head;
   logic [1:0]    occ, occ_after;
   logic          sw_int, pop, issue, bus_ok;
   logic [3:0]    bit_sel;

   assign bus_ok    = bus.ibus_wen & (state_q == ST_IDLE);
   assign pop       = sw_int & bus.s_rdy;
   // Counting this cycle's pop as free space is what lets a 2-entry skid sustain one word per cycle.
   assign occ_after = occ - {1'b0, pop};
   assign issue     = (state_q == ST_STREAM) & ~bus.start & (issued_q < run_q)
                    & (({1'b0, occ_after} + {2'b00, fl_q}) < 3'd2);
   assign bit_sel   = mask_bit_sel(fl_idx_q, run_q);

   sbuf_1r1w #(.AW(AW), .DW(DW)) u_data_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus_ok & ~bus.ibus_wadr[SEL_BIT]),
      .waddr (bus.ibus_wadr[AW-1:0]),
      .wdata (bus.ibus_wdata),
      .re    (issue),
      .raddr (issued_q),
      .rdata (data_rdata)
   );

   // The mask RAM read port is only refreshed at group starts, so its output holds the group's mask word.
   sbuf_1r1w #(.AW(AW), .DW(DW)) u_mask_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus_ok & bus.ibus_wadr[SEL_BIT]),
      .waddr (bus.ibus_wadr[AW-1:0]),
      .wdata (bus.ibus_wdata),
      .re    (issue & (issued_q[3:0] == 4'd0)),
      .raddr ({4'd0, issued_q[AW-1:4]}),
      .rdata (mask_rdata)
   );

   ibuf_skid #(.W(DW + 1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.start),
      .in_valid  (fl_q),
      .in_data   ({mask_rdata[bit_sel], data_rdata}),
      .out_rdy   (bus.s_rdy),
      .out_valid (sw_int),
      .out_data  (skid_head),
      .occ       (occ)
   );

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   ;
         ST_STREAM: if (issue && (issued_q + AW'(1) == run_q)) state_d = ST_DRAIN;
         ST_DRAIN:  if ((occ_after == 2'd0) && !fl_q) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (bus.start) state_d = (bus.run_cntr != '0) ? ST_STREAM : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         run_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         fl_q       <= 1'b0;
         fl_idx_q   <= '0;
      end else begin
         state_q <= state_d;
         fl_q    <= issue;
         if (bus.start) begin
            run_q      <= bus.run_cntr;
            issued_q   <= '0;
            accepted_q <= '0;
         end else begin
            if (issue) begin
               issued_q <= issued_q + AW'(1);
               fl_idx_q <= issued_q;
            end
            if (pop) accepted_q <= accepted_q + AW'(1);
         end
      end
   end

   assign bus.i_running = (state_q != ST_IDLE);
   assign bus.sw        = sw_int;
   assign bus.s_in      = skid_head[DW-1:0];
   assign bus.s_mask    = skid_head[DW];
   assign bus.finish    = pop & ~bus.start & (accepted_q == run_q - AW'(1));

endmodule

// File: tb/tb_ibuf_feed.sv
// Self-checking bench: queue-based reference of the streamed words checked every cycle, plus directed pins.
module tb_ibuf_feed;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ibuf_feed_if ifc ();

   ibuf_feed dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int start_cyc = -100;
   int fin_count = 0;
   int rdy_mode = 0;
   int rdy_phase = 0;
   bit m_running = 1'b0;
   bit run_now;
   bit exp_sw, exp_fin;

   logic [16:0] exp_q[$];
   logic [15:0] sh_data [256];
   logic [15:0] sh_mask [256];
   logic [15:0] cap_data[$];
   logic        cap_mask[$];
   logic        cap_fin[$];
   int          cap_cyc[$];

   bit mask_full [16] = '{1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0};
   bit mask_tail [4]  = '{1,0,0,1};
   bit mask_eight [8] = '{1,1,1,1,0,0,0,0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // s_rdy driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       ifc.s_rdy = 1'b1;
         1:       ifc.s_rdy = ($urandom_range(0, 2) != 0);
         default: ifc.s_rdy = (rdy_phase % 3 == 0);
      endcase
      rdy_phase++;
   end

   // Reference model and per-cycle compare, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_sw", 32'(ifc.sw), 0);
         check("rst_running", 32'(ifc.i_running), 0);
         check("rst_finish", 32'(ifc.finish), 0);
         check("rst_s_in", 32'(ifc.s_in), 0);
         check("rst_s_mask", 32'(ifc.s_mask), 0);
         exp_q.delete();
         m_running = 1'b0;
         start_cyc = -100;
      end else begin
         run_now = m_running;
         exp_sw  = (exp_q.size() > 0) && (cyc >= start_cyc + 3);
         exp_fin = exp_sw && ifc.s_rdy && (exp_q.size() == 1) && !ifc.start;
         check("sw", 32'(ifc.sw), 32'(exp_sw));
         check("i_running", 32'(ifc.i_running), 32'(run_now));
         check("finish", 32'(ifc.finish), 32'(exp_fin));
         if (ifc.sw && exp_q.size() > 0) begin
            check("s_in", 32'(ifc.s_in), 32'(exp_q[0][15:0]));
            check("s_mask", 32'(ifc.s_mask), 32'(exp_q[0][16]));
         end
         if (ifc.finish) fin_count++;
         if (ifc.sw && ifc.s_rdy) begin
            cap_data.push_back(ifc.s_in);
            cap_mask.push_back(ifc.s_mask);
            cap_fin.push_back(ifc.finish);
            cap_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) m_running = 1'b0;
            end
         end
         if (ifc.ibus_wen && !run_now) begin
            if (ifc.ibus_wadr[8]) sh_mask[ifc.ibus_wadr[7:0]] = ifc.ibus_wdata;
            else                  sh_data[ifc.ibus_wadr[7:0]] = ifc.ibus_wdata;
         end
         if (ifc.start) begin
            exp_q.delete();
            for (int i = 0; i < int'(ifc.run_cntr); i++) begin
               int base, rem, b;
               base = (i / 16) * 16;
               rem  = int'(ifc.run_cntr) - base;
               b    = (rem >= 16) ? 15 - (i % 16) : rem - 1 - (i % 16);
               exp_q.push_back({sh_mask[i / 16][b], sh_data[i]});
            end
            m_running = (ifc.run_cntr != 8'd0);
            start_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic sel, input logic [7:0] adr, input logic [15:0] d);
      ifc.ibus_wadr  = {sel, adr};
      ifc.ibus_wdata = d;
      ifc.ibus_wen   = 1'b1;
      step();
      ifc.ibus_wen   = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] n);
      ifc.run_cntr = n;
      ifc.start    = 1'b1;
      step();
      ifc.start    = 1'b0;
   endtask

   task automatic clear_cap();
      cap_data.delete();
      cap_mask.delete();
      cap_fin.delete();
      cap_cyc.delete();
   endtask

   task automatic wait_idle(input int budget, input string tag);
      bit done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         step();
         if (!ifc.i_running && !ifc.sw) begin
            done = 1'b1;
            break;
         end
      end
      check({tag, "_idle_reached"}, 32'(done), 1);
   endtask

   task automatic random_run(input int n, input bit allow_abort);
      bit done = 1'b0;
      do_start(8'(n));
      for (int c = 0; c < 2000; c++) begin
         if (!ifc.i_running && !ifc.sw) begin
            done = 1'b1;
            break;
         end
         ifc.ibus_wen   = ($urandom_range(0, 7) == 0);
         ifc.ibus_wadr  = 9'($urandom);
         ifc.ibus_wdata = 16'($urandom);
         ifc.run_cntr   = 8'($urandom_range(0, 30));
         ifc.start      = allow_abort && ($urandom_range(0, 60) == 0);
         step();
      end
      ifc.ibus_wen = 1'b0;
      ifc.start    = 1'b0;
      check("rand_idle_reached", 32'(done), 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st, fc0;
      ifc.ibus_wen   = 1'b0;
      ifc.ibus_wadr  = '0;
      ifc.ibus_wdata = '0;
      ifc.start      = 1'b0;
      ifc.run_cntr   = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 256; i++) bus_write(1'b0, 8'(i), 16'(i * 37 + 5));
      for (int i = 0; i < 256; i++) bus_write(1'b1, 8'(i), 16'(i * 13));
      for (int i = 0; i < 20; i++)  bus_write(1'b0, 8'(i), 16'(16'h100 + i));
      bus_write(1'b1, 8'd0, 16'hA5F0);
      bus_write(1'b1, 8'd1, 16'h0009);

      // Full group of 16 at full rate
      rdy_mode = 0;
      clear_cap();
      fc0 = fin_count;
      do_start(8'd16);
      st = start_cyc;
      wait_idle(200, "t1");
      check("t1_count", 32'(cap_data.size()), 16);
      for (int i = 0; i < 16 && i < cap_data.size(); i++) begin
         check("t1_data", 32'(cap_data[i]), 32'(16'h100 + i));
         check("t1_mask", 32'(cap_mask[i]), 32'(mask_full[i]));
         check("t1_fin", 32'(cap_fin[i]), 32'(i == 15));
      end
      if (cap_cyc.size() == 16) begin
         check("t1_first_latency", 32'(cap_cyc[0] - st), 3);
         check("t1_last_latency", 32'(cap_cyc[15] - st), 18);
      end
      check("t1_fin_count", 32'(fin_count - fc0), 1);

      // Partial final group of 4
      clear_cap();
      do_start(8'd20);
      wait_idle(200, "t2");
      check("t2_count", 32'(cap_data.size()), 20);
      for (int i = 16; i < 20 && i < cap_data.size(); i++) begin
         check("t2_data", 32'(cap_data[i]), 32'(16'h100 + i));
         check("t2_mask", 32'(cap_mask[i]), 32'(mask_tail[i - 16]));
      end
      if (cap_fin.size() == 20) check("t2_fin_last", 32'(cap_fin[19]), 1);

      // Back-pressure 1,0,0 pattern
      rdy_mode = 2;
      clear_cap();
      fc0 = fin_count;
      do_start(8'd8);
      wait_idle(200, "t3");
      rdy_mode = 0;
      check("t3_count", 32'(cap_data.size()), 8);
      for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
         check("t3_data", 32'(cap_data[i]), 32'(16'h100 + i));
         check("t3_mask", 32'(cap_mask[i]), 32'(mask_eight[i]));
      end
      check("t3_fin_count", 32'(fin_count - fc0), 1);

      // Abort on the 5th transfer and restart with 4
      clear_cap();
      fc0 = fin_count;
      do_start(8'd10);
      repeat (6) step();
      do_start(8'd4);
      st = start_cyc;
      wait_idle(200, "t5");
      check("t5_count", 32'(cap_data.size()), 9);
      if (cap_data.size() == 9) begin
         for (int i = 0; i < 5; i++) check("t5_first_run", 32'(cap_data[i]), 32'(16'h100 + i));
         for (int i = 0; i < 4; i++) check("t5_second_run", 32'(cap_data[5 + i]), 32'(16'h100 + i));
         check("t5_fin_last", 32'(cap_fin[8]), 1);
         check("t5_restart_latency", 32'(cap_cyc[5] - st), 3);
      end
      check("t5_fin_count", 32'(fin_count - fc0), 1);

      // Bus write while running is dropped; the same write in IDLE lands
      clear_cap();
      do_start(8'd8);
      step();
      bus_write(1'b0, 8'd3, 16'hDEAD);
      wait_idle(200, "t4a");
      if (cap_data.size() == 8) check("t4_word3_old", 32'(cap_data[3]), 32'h103);
      bus_write(1'b0, 8'd3, 16'hDEAD);
      clear_cap();
      do_start(8'd8);
      wait_idle(200, "t4b");
      if (cap_data.size() == 8) check("t4_word3_new", 32'(cap_data[3]), 32'hDEAD);
      bus_write(1'b0, 8'd3, 16'h0103);

      // Zero-length start
      clear_cap();
      fc0 = fin_count;
      do_start(8'd0);
      repeat (5) step();
      check("t6_zero_no_sw", 32'(cap_data.size()), 0);
      check("t6_zero_no_fin", 32'(fin_count - fc0), 0);
      check("t6_zero_running", 32'(ifc.i_running), 0);

      // Reset mid-stream, RAM contents survive
      do_start(8'd30);
      repeat (8) step();
      rst_n = 1'b0;
      #1;
      check("t7_rst_sw", 32'(ifc.sw), 0);
      check("t7_rst_running", 32'(ifc.i_running), 0);
      check("t7_rst_s_in", 32'(ifc.s_in), 0);
      step();
      rst_n = 1'b1;
      step();
      clear_cap();
      do_start(8'd4);
      wait_idle(200, "t7");
      check("t7_count", 32'(cap_data.size()), 4);
      for (int i = 0; i < 4 && i < cap_data.size(); i++)
         check("t7_data", 32'(cap_data[i]), 32'(16'h100 + i));

      // Randomized runs, stalls, aborts and bus traffic
      rdy_mode = 1;
      for (int r = 0; r < 40; r++) begin
         int n;
         repeat ($urandom_range(0, 6)) begin
            if ($urandom_range(0, 1) == 1) bus_write(1'b1, 8'($urandom_range(0, 15)), 16'($urandom));
            else                           bus_write(1'b0, 8'($urandom_range(0, 255)), 16'($urandom));
         end
         n = (r % 10 == 9) ? 255 : $urandom_range(0, 40);
         random_run(n, (r % 3) == 0);
      end
      rdy_mode = 0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
